ysyx_23060203_ifu: RTL and testbench
====================================

# ysyx_23060203_ifu

Instruction fetch unit: owns the PC, drives the ICache lookup address, and hands fetched instructions to the IDU through a registered valid/ready stage. It sits directly upstream of the ICache. It takes redirects (jumps, traps, fence.i) from the back-end. PC changes are held off while the ICache is refilling, so the ICache always sees a stable address during a miss.

## Interface
- `RESET_PC`, default 32'h3000_0000: PC loaded on reset.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; asserted (0) resets all state immediately.
- `jump_en`  in  1  back-end redirect strobe, one cycle.
- `jump_pc`  in  32  redirect target, valid with `jump_en`.
- `fencei_req`  in  1  fence.i flag; meaningful only with `jump_en` (target = fence.i PC+4); ignored otherwise.
- `icache_addr`  out  32  lookup address (= `pc`).
- `icache_hit`  in  1  ICache hit for `icache_addr`, same cycle.
- `icache_inst`  in  32  instruction word for `icache_addr`, valid when `icache_hit`.
- `icache_fencei`  out  1  one-cycle invalidate-all pulse to ICache.
- `out_valid`  out  1  IDU stage valid.
- `out_ready`  in  1  IDU accepts.
- `out_pc`  out  32  PC of held instruction.
- `out_inst`  out  32  held instruction.

## Operation
- Registers: `pc`, `state` (RUN, PARK), `pend_pc`, `pend_fencei`, output stage (`out_valid`, `out_pc`, `out_inst`).
- Invariant: `pc` updates only at an edge where `icache_hit`=1. This keeps the ICache index and tag stable through a refill.
- `slot_free` = ~`out_valid` | `out_ready`.
- `fire` = RUN & `icache_hit` & `slot_free` & ~`jump_en`. On fire: `out_*` <= {1, `pc`, `icache_inst`}; `pc` <= `pc`+4 (mod 2^32).
- If no fire and `out_valid` & `out_ready`: `out_valid` <= 0.
- Redirect in RUN with `icache_hit`=1:
  - `pc` <= `jump_pc` and `out_valid` <= 0; the held instruction is flushed even if `out_ready`.
  - `icache_fencei` = `fencei_req` in this same cycle (combinational).
- Redirect in RUN with `icache_hit`=0:
  - `pend_pc` <= `jump_pc`, `pend_fencei` <= `fencei_req`, `out_valid` <= 0, state -> PARK.
  - `pc` is unchanged.
- PARK:
  - No fire.
  - A new `jump_en` overwrites `pend_pc` and ORs `fencei_req` into `pend_fencei`.
  - Once `icache_hit`=1: `pc` <= newest pending target (a same-cycle `jump_pc` wins), `icache_fencei` = `pend_fencei` | (`jump_en` & `fencei_req`), `pend_fencei` <= 0, state -> RUN.
- `icache_fencei` is never asserted in a cycle with `icache_hit`=0.

## Timing
- Reset values: `pc`=`RESET_PC`, state=RUN, `out_valid`=0, `out_pc`=0, `out_inst`=0, `pend_pc`=0, `pend_fencei`=0. `icache_fencei`=0 during reset.
- Hit latency: the instruction is visible on `out_*` the cycle after the hit. Throughput is 1 instruction/cycle with `out_ready` held high.
- Miss: `icache_addr` is held until `icache_hit`; fetch resumes the same cycle the hit rises.
- Redirect while hitting: the new `icache_addr` appears next cycle, and the first redirected instruction is on `out_*` no earlier than 2 cycles after `jump_en`.
- `out_*` are stable while `out_valid` & ~`out_ready`, unless flushed by `jump_en`.
- Reset asserted mid-refill: state clears asynchronously. The ICache is reset by the same net; no handshake recovery is needed.

## Structure
- Shared package `ysyx_23060203_pkg`: `ifu_state_t` enum {RUN, PARK} and a `RESET_PC_DEFAULT` constant.
- Single module; no sub-module. The redirect buffer is two registers and does not justify one.

## Test plan
- Reset release with a hit model always returning `inst`=PC, `out_ready`=1 -> `out_pc` 3000_0000, 3000_0004, 3000_0008 on consecutive cycles starting one cycle after the first hit.
- `icache_hit` low for 5 cycles at pc 3000_0010 -> `icache_addr` constant 3000_0010 for those cycles, `out_valid` 0 after drain; 3000_0010 issued the cycle after hit rises.
- `out_ready`=0 for 3 cycles with `out_valid`=1 -> `out_pc`/`out_inst` unchanged, `pc` advances at most one step.
- `jump_en`, `jump_pc`=8000_0100 during a hit -> `out_valid` 0 next cycle, `icache_addr`=8000_0100 next cycle, no instruction from the old path issued.
- `jump_en`+`fencei_req` (target 3000_0040) while hit=0 at pc 3000_0020 -> `icache_addr` stays 3000_0020 until hit. `icache_fencei` is a single pulse in the hit cycle, then `icache_addr`=3000_0040.
- Two `jump_en` in PARK (first with `fencei_req`, then 3000_0080 without) -> target 3000_0080 applied and `icache_fencei` still pulses once.

Source files
------------

// File: rtl/ysyx_23060203_pkg.sv
// ysyx_23060203_pkg: shared types and constants for the fetch unit
package ysyx_23060203_pkg;
  typedef enum logic {RUN, PARK} ifu_state_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;
endpackage

// File: rtl/ysyx_23060203_ifu.sv
// ysyx_23060203_ifu: PC owner, ICache lookup driver and registered IDU output stage
module ysyx_23060203_ifu
  import ysyx_23060203_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        jump_en,
  input  logic [31:0] jump_pc,
  input  logic        fencei_req,
  output logic [31:0] icache_addr,
  input  logic        icache_hit,
  input  logic [31:0] icache_inst,
  output logic        icache_fencei,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);
  ifu_state_t  state;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic        pend_fencei;
  logic        slot_free;
  logic        fire;
  logic        run;

  assign run         = state == RUN;
  assign slot_free   = ~out_valid | out_ready;
  assign fire        = run & icache_hit & slot_free & ~jump_en;
  assign icache_addr = pc;
  // Invalidate only when the PC actually moves, so a refill never sees it; gated by reset
  assign icache_fencei = reset & icache_hit & ((jump_en & fencei_req) | (~run & pend_fencei));

  // PC only moves on a hit edge; redirects seen during a miss are parked until the hit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      pend_pc     <= '0;
      pend_fencei <= 1'b0;
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_inst    <= '0;
    end else if (run) begin
      if (jump_en) begin
        out_valid <= 1'b0;
        if (icache_hit) pc <= jump_pc;
        else begin
          pend_pc     <= jump_pc;
          pend_fencei <= fencei_req;
          state       <= PARK;
        end
      end else if (fire) begin
        out_valid <= 1'b1;
        out_pc    <= pc;
        out_inst  <= icache_inst;
        pc        <= pc + 32'd4;
      end else if (out_valid & out_ready) out_valid <= 1'b0;
    end else begin
      if (out_valid & out_ready) out_valid <= 1'b0;
      if (jump_en) pend_pc <= jump_pc;
      if (icache_hit) begin
        pc          <= jump_en ? jump_pc : pend_pc;
        pend_fencei <= 1'b0;
        state       <= RUN;
      end else if (jump_en) pend_fencei <= pend_fencei | fencei_req;
    end
  end
endmodule

// File: tb/tb_ysyx_23060203_ifu.sv
// tb_ysyx_23060203_ifu: directed checks of fetch, miss stall, backpressure and redirects
module tb_ysyx_23060203_ifu;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_pc = '0;
  logic        fencei_req = 1'b0;
  logic [31:0] icache_addr;
  logic        icache_hit = 1'b0;
  logic [31:0] icache_inst;
  logic        icache_fencei;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  int          vecs = 0;
  int          miss = 0;

  assign icache_inst = icache_addr;

  always #5 clock = ~clock;

  ysyx_23060203_ifu dut (
    .clock(clock), .reset(reset), .jump_en(jump_en), .jump_pc(jump_pc),
    .fencei_req(fencei_req), .icache_addr(icache_addr), .icache_hit(icache_hit),
    .icache_inst(icache_inst), .icache_fencei(icache_fencei), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    icache_hit = 1'b1;
    jump_en = 1'b1;
    fencei_req = 1'b1;
    #1;
    chk("rst_fencei", {31'b0, icache_fencei}, 32'd0);
    step();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_addr", icache_addr, 32'h3000_0000);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_inst", out_inst, 32'h0);
    jump_en = 1'b0;
    fencei_req = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("seq_valid", {31'b0, out_valid}, 32'd1);
      chk("seq_pc", out_pc, 32'h3000_0000 + 32'(4 * i));
      chk("seq_inst", out_inst, 32'h3000_0000 + 32'(4 * i));
    end
    icache_hit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("miss_addr", icache_addr, 32'h3000_0010);
      chk("miss_valid", {31'b0, out_valid}, 32'd0);
    end
    icache_hit = 1'b1;
    step();
    chk("resume_pc", out_pc, 32'h3000_0010);
    chk("resume_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_pc", out_pc, 32'h3000_0010);
      chk("hold_inst", out_inst, 32'h3000_0010);
      chk("hold_addr", icache_addr, 32'h3000_0014);
    end
    out_ready = 1'b1;
    step();
    chk("release_pc", out_pc, 32'h3000_0014);
    jump_en = 1'b1;
    jump_pc = 32'h8000_0100;
    #1;
    chk("jmp_nofencei", {31'b0, icache_fencei}, 32'd0);
    step();
    chk("jmp_valid", {31'b0, out_valid}, 32'd0);
    chk("jmp_addr", icache_addr, 32'h8000_0100);
    jump_en = 1'b0;
    step();
    chk("jmp_out_pc", out_pc, 32'h8000_0100);
    chk("jmp_out_inst", out_inst, 32'h8000_0100);
    jump_en = 1'b1;
    jump_pc = 32'h3000_0020;
    step();
    chk("jmp2_addr", icache_addr, 32'h3000_0020);
    icache_hit = 1'b0;
    jump_pc = 32'h3000_0040;
    fencei_req = 1'b1;
    #1;
    chk("park_nofencei", {31'b0, icache_fencei}, 32'd0);
    step();
    jump_en = 1'b0;
    fencei_req = 1'b0;
    chk("park_addr0", icache_addr, 32'h3000_0020);
    chk("park_valid", {31'b0, out_valid}, 32'd0);
    step();
    chk("park_addr1", icache_addr, 32'h3000_0020);
    chk("park_fencei_low", {31'b0, icache_fencei}, 32'd0);
    icache_hit = 1'b1;
    #1;
    chk("park_fencei", {31'b0, icache_fencei}, 32'd1);
    step();
    chk("unpark_addr", icache_addr, 32'h3000_0040);
    chk("unpark_fencei", {31'b0, icache_fencei}, 32'd0);
    chk("unpark_valid", {31'b0, out_valid}, 32'd0);
    step();
    chk("unpark_out", out_pc, 32'h3000_0040);
    icache_hit = 1'b0;
    jump_en = 1'b1;
    jump_pc = 32'h3000_0060;
    fencei_req = 1'b1;
    step();
    jump_pc = 32'h3000_0080;
    fencei_req = 1'b0;
    #1;
    chk("dbl_fencei_low", {31'b0, icache_fencei}, 32'd0);
    step();
    jump_en = 1'b0;
    chk("dbl_addr", icache_addr, 32'h3000_0044);
    icache_hit = 1'b1;
    #1;
    chk("dbl_fencei", {31'b0, icache_fencei}, 32'd1);
    step();
    chk("dbl_target", icache_addr, 32'h3000_0080);
    chk("dbl_fencei_once", {31'b0, icache_fencei}, 32'd0);
    icache_hit = 1'b0;
    jump_en = 1'b1;
    jump_pc = 32'h3000_00c0;
    step();
    jump_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_addr", icache_addr, 32'h3000_0000);
    chk("async_valid", {31'b0, out_valid}, 32'd0);
    icache_hit = 1'b1;
    reset = 1'b1;
    step();
    chk("post_rst_pc", out_pc, 32'h3000_0000);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
